// File: rtl/traffic_pkg.sv
// Shared encodings for the intersection: phase codes, arbiter states and
// small selection helpers used by the scheduler and the light controller.
package traffic_pkg;

    typedef enum logic [1:0] {
        PH_NONE    = 2'd0,
        PH_LA_RUE  = 2'd1,
        PH_ORCHARD = 2'd2,
        PH_PED     = 2'd3
    } phase_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OFFER = 2'd1,
        ST_BUSY  = 2'd2
    } arb_state_e;

    // One-hot request bit for a phase, ordered {ped, orchard, la_rue}.
    function automatic logic [2:0] phase_mask(input phase_e ph);
        logic [2:0] m;
        case (ph)
            PH_LA_RUE:  m = 3'b001;
            PH_ORCHARD: m = 3'b010;
            PH_PED:     m = 3'b100;
            default:    m = 3'b000;
        endcase
        return m;
    endfunction

    // Round-robin LA_RUE -> ORCHARD -> PED, starting after the last served phase.
    function automatic phase_e rr_pick(input logic [2:0] req, input phase_e last);
        phase_e pick;
        case (last)
            PH_LA_RUE: begin
                if (req[1])      pick = PH_ORCHARD;
                else if (req[2]) pick = PH_PED;
                else if (req[0]) pick = PH_LA_RUE;
                else             pick = PH_NONE;
            end
            PH_ORCHARD: begin
                if (req[2])      pick = PH_PED;
                else if (req[0]) pick = PH_LA_RUE;
                else if (req[1]) pick = PH_ORCHARD;
                else             pick = PH_NONE;
            end
            default: begin
                if (req[0])      pick = PH_LA_RUE;
                else if (req[1]) pick = PH_ORCHARD;
                else if (req[2]) pick = PH_PED;
                else             pick = PH_NONE;
            end
        endcase
        return pick;
    endfunction

    // Fixed-priority pick among starved phases: PED, then ORCHARD, then LA_RUE.
    function automatic phase_e starve_pick(input logic [2:0] starved);
        phase_e pick;
        if (starved[2])      pick = PH_PED;
        else if (starved[1]) pick = PH_ORCHARD;
        else if (starved[0]) pick = PH_LA_RUE;
        else                 pick = PH_NONE;
        return pick;
    endfunction

endpackage

// File: rtl/signal_phase_scheduler_if.sv
// Grant handshake between the phase scheduler (master) and the light
// controller (slave).
interface signal_phase_scheduler_if;
    logic       grant_valid;
    logic [1:0] grant_phase;
    logic       phase_ready;
    logic       phase_done;

    modport master (
        output grant_valid,
        output grant_phase,
        input  phase_ready,
        input  phase_done
    );

    modport slave (
        input  grant_valid,
        input  grant_phase,
        output phase_ready,
        output phase_done
    );
endinterface

// File: rtl/sensor_debounce.sv
// Two-flop synchronizer followed by a stable-count debouncer. The rise
// strobe is high in the cycle whose edge commits a 0->1 change, so a
// consumer registering it sees the request on that same edge.
module sensor_debounce #(
    parameter int unsigned DEBOUNCE_CYC = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic rise
);
    localparam int unsigned CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic             sync1_r;
    logic             sync2_r;
    logic             dout_r;
    logic [CNT_W-1:0] cnt_r;
    logic             diff_s;
    logic             commit_s;

    assign diff_s   = sync2_r ^ dout_r;
    assign commit_s = diff_s && (cnt_r == CNT_LAST);
    assign rise     = commit_s && sync2_r;

    // Bring the asynchronous input into the clk domain.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= din;
            sync2_r <= sync1_r;
        end
    end

    // Count consecutive differing cycles; any agreement restarts the count.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_r  <= '0;
            dout_r <= 1'b0;
        end else if (!diff_s) begin
            cnt_r  <= '0;
        end else if (commit_s) begin
            cnt_r  <= '0;
            dout_r <= sync2_r;
        end else begin
            cnt_r  <= cnt_r + CNT_W'(1);
        end
    end

endmodule

// File: rtl/signal_phase_scheduler.sv
// Intersection phase scheduler: debounced requests are latched as pending,
// arbitrated round-robin with a starvation override, and offered one at a
// time to the light controller over a valid/ready handshake.
module signal_phase_scheduler
    import traffic_pkg::*;
#(
    parameter int unsigned TICK_DIV     = 25000000,
    parameter int unsigned DEBOUNCE_CYC = 16,
    parameter int unsigned MAX_WAIT_S   = 30
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             la_rue_sensor,
    input  logic                             orchard_sensor,
    input  logic                             ped_button_n,
    signal_phase_scheduler_if.master         bus,
    output logic                             sec_tick,
    output logic [2:0]                       pending,
    output logic                             starve_alarm
);
    localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic [7:0] MAX_W = 8'(MAX_WAIT_S);

    logic [PRE_W-1:0] pre_cnt_r;
    logic [PRE_W-1:0] pre_next_s;
    logic             sec_tick_r;

    logic [2:0]       rise_s;
    logic [2:0]       pending_r;
    logic [2:0]       pending_next_s;
    logic [2:0]       hs_mask_s;
    logic [2:0]       service_mask_s;
    logic [2:0]       starved_s;
    logic             hs_s;
    logic [7:0]       wait_r [3];
    logic             starve_r;

    arb_state_e       state_r, state_n;
    phase_e           grant_phase_r, phase_n;
    phase_e           last_served_r, last_n;
    logic             grant_valid_r, valid_n;

    sensor_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_la_rue (
        .clk(clk), .reset_n(reset_n), .din(la_rue_sensor), .rise(rise_s[0])
    );
    sensor_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_orchard (
        .clk(clk), .reset_n(reset_n), .din(orchard_sensor), .rise(rise_s[1])
    );
    sensor_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_ped (
        .clk(clk), .reset_n(reset_n), .din(~ped_button_n), .rise(rise_s[2])
    );

    // Next prescaler count, wrapping after TICK_DIV-1.
    always_comb begin
        if (pre_cnt_r == PRE_LAST) begin
            pre_next_s = '0;
        end else begin
            pre_next_s = pre_cnt_r + PRE_W'(1);
        end
    end

    // Prescaler; the tick is registered so it is high while the count is TICK_DIV-1.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pre_cnt_r  <= '0;
            sec_tick_r <= 1'b0;
        end else begin
            pre_cnt_r  <= pre_next_s;
            sec_tick_r <= (pre_next_s == PRE_LAST);
        end
    end

    // Handshake decode, pending update (new request beats the clear) and starvation flags.
    always_comb begin
        hs_s = (state_r == ST_OFFER) && bus.phase_ready;
        if (hs_s) begin
            hs_mask_s = phase_mask(grant_phase_r);
        end else begin
            hs_mask_s = 3'b000;
        end
        if (state_r != ST_IDLE) begin
            service_mask_s = phase_mask(grant_phase_r);
        end else begin
            service_mask_s = 3'b000;
        end
        pending_next_s = (pending_r & ~hs_mask_s) | rise_s;
        for (int i = 0; i < 3; i++) begin
            starved_s[i] = pending_r[i] && (wait_r[i] >= MAX_W);
        end
    end

    // Pending latch and registered starvation alarm.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pending_r <= 3'b000;
            starve_r  <= 1'b0;
        end else begin
            pending_r <= pending_next_s;
            starve_r  <= |starved_s;
        end
    end

    // Per-phase wait counters in seconds, saturating, cleared when served.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!reset_n) begin
                wait_r[i] <= 8'd0;
            end else if (hs_mask_s[i]) begin
                wait_r[i] <= 8'd0;
            end else if (sec_tick_r && pending_r[i] && !service_mask_s[i] && (wait_r[i] != 8'hFF)) begin
                wait_r[i] <= wait_r[i] + 8'd1;
            end else begin
                wait_r[i] <= wait_r[i];
            end
        end
    end

    // Arbiter next state and next grant outputs.
    always_comb begin
        state_n = state_r;
        valid_n = grant_valid_r;
        phase_n = grant_phase_r;
        last_n  = last_served_r;
        case (state_r)
            ST_IDLE: begin
                if (pending_r != 3'b000) begin
                    state_n = ST_OFFER;
                    valid_n = 1'b1;
                    if (|starved_s) begin
                        phase_n = starve_pick(starved_s);
                    end else begin
                        phase_n = rr_pick(pending_r, last_served_r);
                    end
                end else begin
                    valid_n = 1'b0;
                    phase_n = PH_NONE;
                end
            end
            ST_OFFER: begin
                if (bus.phase_ready) begin
                    state_n = ST_BUSY;
                    valid_n = 1'b0;
                    last_n  = grant_phase_r;
                end else begin
                    valid_n = 1'b1;
                end
            end
            ST_BUSY: begin
                if (bus.phase_done) begin
                    state_n = ST_IDLE;
                    valid_n = 1'b0;
                    phase_n = PH_NONE;
                end else begin
                    valid_n = 1'b0;
                end
            end
            default: begin
                state_n = ST_IDLE;
                valid_n = 1'b0;
                phase_n = PH_NONE;
            end
        endcase
    end

    // Arbiter state and registered grant outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r       <= ST_IDLE;
            grant_valid_r <= 1'b0;
            grant_phase_r <= PH_NONE;
            last_served_r <= PH_PED;
        end else begin
            state_r       <= state_n;
            grant_valid_r <= valid_n;
            grant_phase_r <= phase_n;
            last_served_r <= last_n;
        end
    end

    assign bus.grant_valid = grant_valid_r;
    assign bus.grant_phase = grant_phase_r;
    assign sec_tick        = sec_tick_r;
    assign pending         = pending_r;
    assign starve_alarm    = starve_r;

endmodule

// File: tb/tb_signal_phase_scheduler.sv
// Directed bench for signal_phase_scheduler with small timing parameters.
module tb_signal_phase_scheduler;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       la_rue_sensor;
    logic       orchard_sensor;
    logic       ped_button_n;
    logic       sec_tick;
    logic [2:0] pending;
    logic       starve_alarm;

    int checks   = 0;
    int failures = 0;

    signal_phase_scheduler_if bus_if ();

    signal_phase_scheduler #(
        .TICK_DIV(10), .DEBOUNCE_CYC(4), .MAX_WAIT_S(3)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .la_rue_sensor  (la_rue_sensor),
        .orchard_sensor (orchard_sensor),
        .ped_button_n   (ped_button_n),
        .bus            (bus_if),
        .sec_tick       (sec_tick),
        .pending        (pending),
        .starve_alarm   (starve_alarm)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       la;
        logic       orch;
        logic       ped_n;
        logic       ready;
        logic       done;
        logic       exp_valid;
        logic [1:0] exp_phase;
        logic [2:0] exp_pend;
    } vec_t;

    vec_t vecs [12];

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic reset_seq();
        reset_n        = 1'b0;
        la_rue_sensor  = 1'b0;
        orchard_sensor = 1'b0;
        ped_button_n   = 1'b1;
        bus_if.phase_ready = 1'b0;
        bus_if.phase_done  = 1'b0;
        step(3);
        reset_n = 1'b1;
    endtask

    initial begin
        int ticks;
        int first_tick;
        int last_tick;
        logic bad_idle;
        logic found;
        logic [1:0] exp_order [3];

        // Orchard request through grant, handshake and done, one row per cycle.
        for (int i = 0; i < 5; i++) vecs[i] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 3'b000};
        vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 3'b010};
        vecs[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 3'b010};
        vecs[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 3'b000};
        vecs[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 3'b000};
        vecs[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 3'b000};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 3'b000};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 3'b000};

        // Reset values and idle behaviour with the one-second prescaler.
        reset_seq();
        check("reset valid", {31'd0, bus_if.grant_valid}, 32'd0);
        check("reset phase", {30'd0, bus_if.grant_phase}, 32'd0);
        check("reset pending", {29'd0, pending}, 32'd0);
        check("reset tick", {31'd0, sec_tick}, 32'd0);
        check("reset starve", {31'd0, starve_alarm}, 32'd0);
        ticks = 0; first_tick = -1; last_tick = -1; bad_idle = 1'b0;
        for (int k = 1; k <= 35; k++) begin
            step(1);
            if (sec_tick) begin
                ticks++;
                if (first_tick < 0) first_tick = k;
                last_tick = k;
            end
            if (bus_if.grant_valid || (pending != 3'b000)) bad_idle = 1'b1;
        end
        check("tick count", ticks, 32'd3);
        check("first tick", first_tick, 32'd9);
        check("last tick", last_tick, 32'd29);
        check("idle quiet", {31'd0, bad_idle}, 32'd0);

        // Table-driven orchard sequence.
        reset_seq();
        for (int i = 0; i < 12; i++) begin
            la_rue_sensor      = vecs[i].la;
            orchard_sensor     = vecs[i].orch;
            ped_button_n       = vecs[i].ped_n;
            bus_if.phase_ready = vecs[i].ready;
            bus_if.phase_done  = vecs[i].done;
            step(1);
            check($sformatf("vec%0d valid", i), {31'd0, bus_if.grant_valid}, {31'd0, vecs[i].exp_valid});
            check($sformatf("vec%0d phase", i), {30'd0, bus_if.grant_phase}, {30'd0, vecs[i].exp_phase});
            check($sformatf("vec%0d pending", i), {29'd0, pending}, {29'd0, vecs[i].exp_pend});
        end

        // Button bounce rejection, then a held press with exact latency.
        reset_seq();
        ped_button_n = 1'b0;
        step(3);
        ped_button_n = 1'b1;
        step(12);
        check("bounce reject", {29'd0, pending}, 32'd0);
        ped_button_n = 1'b0;
        step(5);
        check("ped latency-1", {29'd0, pending}, 32'd0);
        step(1);
        check("ped latency", {29'd0, pending}, 32'b100);
        step(2);
        check("ped offer valid", {31'd0, bus_if.grant_valid}, 32'd1);
        check("ped offer phase", {30'd0, bus_if.grant_phase}, 32'd3);

        // All three pending at once: round-robin order from reset.
        reset_seq();
        exp_order[0] = 2'd1; exp_order[1] = 2'd2; exp_order[2] = 2'd3;
        la_rue_sensor = 1'b1; orchard_sensor = 1'b1; ped_button_n = 1'b0;
        bus_if.phase_ready = 1'b1;
        for (int g = 0; g < 3; g++) begin
            found = 1'b0;
            for (int t = 0; t < 20 && !found; t++) begin
                step(1);
                if (bus_if.grant_valid) found = 1'b1;
            end
            check($sformatf("rr grant%0d seen", g), {31'd0, found}, 32'd1);
            check($sformatf("rr grant%0d phase", g), {30'd0, bus_if.grant_phase}, {30'd0, exp_order[g]});
            step(1);
            bus_if.phase_done = 1'b1;
            step(1);
            bus_if.phase_done = 1'b0;
        end
        bus_if.phase_ready = 1'b0;

        // Long OFFER on LA_RUE starves PED; ORCHARD arrives later.
        reset_seq();
        la_rue_sensor = 1'b1; ped_button_n = 1'b0;
        for (int k = 1; k <= 45; k++) begin
            bus_if.phase_done = (k == 21);
            if (k == 26) orchard_sensor = 1'b1;
            step(1);
            if (k == 21) begin
                check("done in offer valid", {31'd0, bus_if.grant_valid}, 32'd1);
                check("done in offer phase", {30'd0, bus_if.grant_phase}, 32'd1);
            end
            if (k == 25) check("starve early", {31'd0, starve_alarm}, 32'd0);
            if (k == 45) begin
                check("starve set", {31'd0, starve_alarm}, 32'd1);
                check("offer hold valid", {31'd0, bus_if.grant_valid}, 32'd1);
                check("offer hold phase", {30'd0, bus_if.grant_phase}, 32'd1);
                check("all pending", {29'd0, pending}, 32'b111);
            end
        end
        bus_if.phase_done = 1'b0;
        bus_if.phase_ready = 1'b1;
        step(1);
        check("la busy valid", {31'd0, bus_if.grant_valid}, 32'd0);
        check("la busy phase", {30'd0, bus_if.grant_phase}, 32'd1);
        check("la cleared", {29'd0, pending}, 32'b110);
        bus_if.phase_ready = 1'b0;
        bus_if.phase_done = 1'b1;
        step(1);
        check("la done phase", {30'd0, bus_if.grant_phase}, 32'd0);
        bus_if.phase_done = 1'b0;
        step(1);
        check("override valid", {31'd0, bus_if.grant_valid}, 32'd1);
        check("override phase", {30'd0, bus_if.grant_phase}, 32'd3);

        // Re-press landing exactly on the PED handshake edge.
        ped_button_n = 1'b1;
        step(8);
        ped_button_n = 1'b0;
        step(5);
        bus_if.phase_ready = 1'b1;
        step(1);
        bus_if.phase_ready = 1'b0;
        check("repress pending", {29'd0, pending}, 32'b110);
        check("repress busy valid", {31'd0, bus_if.grant_valid}, 32'd0);
        check("repress busy phase", {30'd0, bus_if.grant_phase}, 32'd3);

        // Reset while BUSY.
        reset_n = 1'b0;
        step(1);
        check("rst busy phase", {30'd0, bus_if.grant_phase}, 32'd0);
        check("rst busy valid", {31'd0, bus_if.grant_valid}, 32'd0);
        check("rst busy pending", {29'd0, pending}, 32'd0);
        check("rst busy starve", {31'd0, starve_alarm}, 32'd0);

        // Reset while OFFER.
        reset_seq();
        la_rue_sensor = 1'b1; orchard_sensor = 1'b0; ped_button_n = 1'b1;
        step(7);
        check("offer before rst", {31'd0, bus_if.grant_valid}, 32'd1);
        reset_n = 1'b0;
        step(1);
        check("rst offer valid", {31'd0, bus_if.grant_valid}, 32'd0);
        check("rst offer phase", {30'd0, bus_if.grant_phase}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
